// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer slice.
//   - operand / result / command widths
//   - ALU function encodings and sequencer FSM states
//   - command record layout {FUN,B,A} and a divide-by-zero detector
package alu_pkg;

    localparam int unsigned OPW  = 4;
    localparam int unsigned RESW = 8;
    localparam int unsigned CMDW = 2 + 2 * OPW;

    localparam logic [RESW-1:0] DIV0_VAL_DEF = 8'hFF;

    typedef enum logic [1:0] {
        FUN_ADD = 2'b00,
        FUN_SUB = 2'b01,
        FUN_MUL = 2'b10,
        FUN_DIV = 2'b11
    } fun_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]     fun;
        logic [OPW-1:0] b;
        logic [OPW-1:0] a;
    } cmd_t;

    function automatic logic is_div0(input cmd_t c);
        return (c.fun == FUN_DIV) && (c.b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, DEPTH entries (power of two) of WIDTH bits.
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   push, wdata       write request / data (ignored while full, even with a pop)
//   pop, rdata        read request / head-of-queue data (show-ahead)
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: feeds a registered 4-bit ALU (1-cycle latency, no reset)
// from a command FIFO and returns results over a valid/ready interface.
// Ports:
//   CLK, RST_N                     clock, asynchronous active-low reset
//   IN_VALID/IN_READY              command handshake; IN_A, IN_B, IN_FUN command fields
//   ALU_A/ALU_B/ALU_FUN            registered operands to the ALU
//   ALU_OUT                        ALU result, one cycle after operands
//   OUT_VALID/OUT_READY            result handshake
//   OUT_RESULT/OUT_FUN/OUT_DIV0    captured result, its function, divide-by-zero flag
//   DIV0_CNT                       saturating count of divide-by-zero commands
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [RESW-1:0]  DIV0_VAL = DIV0_VAL_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [3:0]  IN_A,
    input  logic [3:0]  IN_B,
    input  logic [1:0]  IN_FUN,
    output logic [3:0]  ALU_A,
    output logic [3:0]  ALU_B,
    output logic [1:0]  ALU_FUN,
    input  logic [7:0]  ALU_OUT,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  OUT_RESULT,
    output logic [1:0]  OUT_FUN,
    output logic        OUT_DIV0,
    output logic [7:0]  DIV0_CNT
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    state_e         state;
    state_e         state_nxt;
    cmd_t           in_cmd;
    cmd_t           head;
    logic           head_div0;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           issue;
    logic [1:0]     tag_fun;
    logic           tag_div0;

    assign in_cmd    = {IN_FUN, IN_B, IN_A};
    assign IN_READY  = (fifo_count != CNT_FULL);
    assign head_div0 = is_div0(head);

    // Issue only when the result slot is empty or being drained this edge,
    // so a captured result can never be overwritten.
    assign issue = (state == IDLE) && !fifo_empty && (!OUT_VALID || OUT_READY);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMDW)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (IN_VALID && !fifo_full),
        .wdata (in_cmd),
        .pop   (issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            WAIT:    state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUN    <= '0;
            tag_fun    <= '0;
            tag_div0   <= 1'b0;
            OUT_VALID  <= 1'b0;
            OUT_RESULT <= '0;
            OUT_FUN    <= '0;
            OUT_DIV0   <= 1'b0;
            DIV0_CNT   <= '0;
        end else begin
            if (issue) begin
                ALU_A    <= head.a;
                // A zero divisor is replaced so the ALU never produces X.
                ALU_B    <= head_div0 ? OPW'(1) : head.b;
                ALU_FUN  <= head.fun;
                tag_fun  <= head.fun;
                tag_div0 <= head_div0;
            end
            // ALU_OUT is only trusted here; it is unreset garbage elsewhere.
            if (state == CAPT) begin
                OUT_RESULT <= tag_div0 ? DIV0_VAL : ALU_OUT;
                OUT_FUN    <= tag_fun;
                OUT_DIV0   <= tag_div0;
                OUT_VALID  <= 1'b1;
                if (tag_div0 && (DIV0_CNT != '1)) begin
                    DIV0_CNT <= DIV0_CNT + 8'd1;
                end
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [7:0] res;
    logic [1:0] fun;
    logic       div0;
  } rec_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] IN_A;
  logic [3:0] IN_B;
  logic [1:0] IN_FUN;
  logic [3:0] ALU_A;
  logic [3:0] ALU_B;
  logic [1:0] ALU_FUN;
  logic [7:0] ALU_OUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_RESULT;
  logic [1:0] OUT_FUN;
  logic       OUT_DIV0;
  logic [7:0] DIV0_CNT;

  logic       alu_garbage;
  int         errors = 0;
  int         checks = 0;
  int         div0_exp = 0;
  rec_t       exp_q[$];
  rec_t       obs_q[$];

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(
    .DEPTH    (4),
    .DIV0_VAL (8'hFF)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_A       (IN_A),
    .IN_B       (IN_B),
    .IN_FUN     (IN_FUN),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_RESULT (OUT_RESULT),
    .OUT_FUN    (OUT_FUN),
    .OUT_DIV0   (OUT_DIV0),
    .DIV0_CNT   (DIV0_CNT)
  );

  always @(posedge CLK) begin
    if (alu_garbage) begin
      ALU_OUT <= 8'($urandom);
    end else begin
      case (ALU_FUN)
        2'b00:   ALU_OUT <= {4'd0, ALU_A} + {4'd0, ALU_B};
        2'b01:   ALU_OUT <= {4'd0, ALU_A} - {4'd0, ALU_B};
        2'b10:   ALU_OUT <= {4'd0, ALU_A} * {4'd0, ALU_B};
        default: ALU_OUT <= (ALU_B == 4'd0) ? 8'bx : ({4'd0, ALU_A} / {4'd0, ALU_B});
      endcase
    end
  end

  function automatic rec_t ref_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
    int   ia;
    int   ib;
    int   v;
    rec_t r;
    ia = int'(a);
    ib = int'(b);
    case (f)
      2'b00:   v = ia + ib;
      2'b01:   v = (ia - ib + 256) % 256;
      2'b10:   v = ia * ib;
      default: v = (ib == 0) ? 255 : ia / ib;
    endcase
    r.res  = 8'(v);
    r.fun  = f;
    r.div0 = (f == 2'b11) && (ib == 0);
    return r;
  endfunction

  function automatic logic [7:0] div0_cnt_exp();
    return (div0_exp > 255) ? 8'hFF : 8'(div0_exp);
  endfunction

  task automatic cycle();
    rec_t r;
    if (RST_N) begin
      if (IN_VALID && IN_READY) begin
        r = ref_model(IN_A, IN_B, IN_FUN);
        exp_q.push_back(r);
        if (r.div0) div0_exp++;
      end
      if (OUT_VALID && OUT_READY) begin
        r = {OUT_RESULT, OUT_FUN, OUT_DIV0};
        obs_q.push_back(r);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while ((obs_q.size() < n) && (k < budget)) begin
      cycle();
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [30:0] got;
    RST_N = 1'b0;
    @(negedge CLK);
    got = {IN_READY, ALU_A, ALU_B, ALU_FUN, OUT_VALID, OUT_RESULT, OUT_FUN, OUT_DIV0, DIV0_CNT};
    checks++;
    if (got !== {1'b1, 30'd0}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", got, {1'b1, 30'd0});
    end
    RST_N = 1'b1;
    clear_model();
    div0_exp = 0;
    cycle();
    cycle();
    checks++;
    if ({IN_READY, OUT_VALID} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 10", {IN_READY, OUT_VALID});
    end
  endtask

  task automatic test_single();
    clear_model();
    OUT_READY = 1'b1;
    IN_A = 4'd3; IN_B = 4'd2; IN_FUN = 2'b00; IN_VALID = 1'b1;
    cycle();
    IN_VALID = 1'b0;
    cycle();
    cycle();
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %b expected 0", OUT_VALID);
    end
    cycle();
    checks++;
    if ({OUT_VALID, OUT_RESULT, OUT_FUN, OUT_DIV0} !== {1'b1, 8'h05, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL single_result: got %h expected %h",
               {OUT_VALID, OUT_RESULT, OUT_FUN, OUT_DIV0}, {1'b1, 8'h05, 2'b00, 1'b0});
    end
    cycle();
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_clear: got %b expected 0", OUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [3] = '{4'd2, 4'd15, 4'd13};
    logic [3:0] tb [3] = '{4'd3, 4'd15, 4'd4};
    logic [1:0] tf [3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] tr [3] = '{8'hFF, 8'hE1, 8'h03};
    bit ok;
    clear_model();
    OUT_READY = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      IN_A = ta[i]; IN_B = tb[i]; IN_FUN = tf[i]; IN_VALID = 1'b1;
      cycle();
    end
    IN_VALID = 1'b0;
    wait_results(3, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results expected 3", obs_q.size());
    end
    for (int unsigned i = 0; i < 3; i++) begin
      if (i < obs_q.size()) begin
        checks++;
        if ({obs_q[i].res, obs_q[i].fun, obs_q[i].div0} !== {tr[i], tf[i], 1'b0}) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h expected %h", i,
                   {obs_q[i].res, obs_q[i].fun, obs_q[i].div0}, {tr[i], tf[i], 1'b0});
        end
      end
    end
  endtask

  task automatic test_div0();
    clear_model();
    OUT_READY = 1'b1;
    IN_A = 4'd9; IN_B = 4'd0; IN_FUN = 2'b11; IN_VALID = 1'b1;
    cycle();
    IN_VALID = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if ($isunknown({IN_READY, ALU_A, ALU_B, ALU_FUN, OUT_VALID, OUT_RESULT, OUT_FUN, OUT_DIV0, DIV0_CNT})) begin
        errors++;
        $display("FAIL div0_x_step%0d: got unknown output expected known", k);
      end
      if (k == 1) begin
        checks++;
        if ({ALU_A, ALU_B, ALU_FUN} !== {4'd9, 4'd1, 2'b11}) begin
          errors++;
          $display("FAIL div0_alu_operands: got %h expected %h",
                   {ALU_A, ALU_B, ALU_FUN}, {4'd9, 4'd1, 2'b11});
        end
      end
      if (k == 3) begin
        checks++;
        if ({OUT_VALID, OUT_RESULT, OUT_FUN, OUT_DIV0, DIV0_CNT} !== {1'b1, 8'hFF, 2'b11, 1'b1, 8'd1}) begin
          errors++;
          $display("FAIL div0_result: got %h expected %h",
                   {OUT_VALID, OUT_RESULT, OUT_FUN, OUT_DIV0, DIV0_CNT},
                   {1'b1, 8'hFF, 2'b11, 1'b1, 8'd1});
        end
      end
    end
  endtask

  task automatic test_full();
    logic [3:0] ca [6];
    logic [3:0] cb [6];
    logic [1:0] cf [6];
    logic [3:0] exp_b0;
    int  idx;
    int  k;
    bit  acc;
    clear_model();
    for (int unsigned i = 0; i < 6; i++) begin
      ca[i] = 4'($urandom); cb[i] = 4'($urandom); cf[i] = 2'($urandom);
    end
    exp_b0 = ((cf[0] == 2'b11) && (cb[0] == 4'd0)) ? 4'd1 : cb[0];
    OUT_READY = 1'b0;
    idx = 0;
    IN_A = ca[0]; IN_B = cb[0]; IN_FUN = cf[0]; IN_VALID = 1'b1;
    repeat (14) begin
      acc = IN_VALID && IN_READY;
      cycle();
      if (acc) begin
        idx++;
        if (idx < 6) begin IN_A = ca[idx]; IN_B = cb[idx]; IN_FUN = cf[idx]; end
      end
    end
    checks++;
    if ({exp_q.size() == 5, IN_READY, OUT_VALID, obs_q.size() == 0} !== 4'b1011) begin
      errors++;
      $display("FAIL full_stall: got accepted=%0d in_ready=%b out_valid=%b results=%0d expected 5 0 1 0",
               exp_q.size(), IN_READY, OUT_VALID, obs_q.size());
    end
    checks++;
    if ({ALU_A, ALU_B, ALU_FUN} !== {ca[0], exp_b0, cf[0]}) begin
      errors++;
      $display("FAIL full_no_reissue: got %h expected %h", {ALU_A, ALU_B, ALU_FUN}, {ca[0], exp_b0, cf[0]});
    end
    OUT_READY = 1'b1;
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL full_refuse_on_pop: got %b expected 0", IN_READY);
    end
    cycle();
    checks++;
    if ({IN_READY, exp_q.size() == 5} !== 2'b11) begin
      errors++;
      $display("FAIL full_accept_next: got in_ready=%b accepted=%0d expected 1 5", IN_READY, exp_q.size());
    end
    k = 0;
    while (((idx < 6) || (obs_q.size() < 6)) && (k < 80)) begin
      acc = IN_VALID && IN_READY;
      cycle();
      if (acc) begin
        idx++;
        if (idx >= 6) IN_VALID = 1'b0;
      end
      k++;
    end
    IN_VALID = 1'b0;
    checks++;
    if (obs_q.size() != 6) begin
      errors++;
      $display("FAIL full_drain_count: got %0d expected 6", obs_q.size());
    end
    for (int unsigned i = 0; i < 6; i++) begin
      if ((i < obs_q.size()) && (i < exp_q.size())) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL full_order%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (DIV0_CNT !== div0_cnt_exp()) begin
      errors++;
      $display("FAIL full_div0_cnt: got %0d expected %0d", DIV0_CNT, div0_cnt_exp());
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] got;
    bit ok;
    clear_model();
    OUT_READY = 1'b1;
    IN_A = 4'd7; IN_B = 4'd5; IN_FUN = 2'b10; IN_VALID = 1'b1;
    cycle();
    IN_A = 4'd1; IN_B = 4'd1; IN_FUN = 2'b00;
    cycle();
    IN_VALID = 1'b0;
    checks++;
    if ({ALU_A, ALU_B, ALU_FUN} !== {4'd7, 4'd5, 2'b10}) begin
      errors++;
      $display("FAIL rst_mid_setup: got %h expected %h", {ALU_A, ALU_B, ALU_FUN}, {4'd7, 4'd5, 2'b10});
    end
    #2 RST_N = 1'b0;
    #1;
    got = {IN_READY, ALU_A, ALU_B, ALU_FUN, OUT_VALID, OUT_RESULT, OUT_FUN, OUT_DIV0, DIV0_CNT};
    checks++;
    if (got !== {1'b1, 30'd0}) begin
      errors++;
      $display("FAIL rst_mid_async: got %h expected %h", got, {1'b1, 30'd0});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    clear_model();
    div0_exp = 0;
    alu_garbage = 1'b1;
    repeat (10) cycle();
    checks++;
    if ({OUT_VALID, obs_q.size() == 0, IN_READY} !== 3'b011) begin
      errors++;
      $display("FAIL rst_mid_stale: got out_valid=%b results=%0d in_ready=%b expected 0 0 1",
               OUT_VALID, obs_q.size(), IN_READY);
    end
    alu_garbage = 1'b0;
    IN_A = 4'd4; IN_B = 4'd9; IN_FUN = 2'b00; IN_VALID = 1'b1;
    cycle();
    IN_VALID = 1'b0;
    wait_results(1, 20, ok);
    checks++;
    if (!ok || (obs_q[0] !== {8'd13, 2'b00, 1'b0})) begin
      errors++;
      $display("FAIL rst_mid_recover: got %h expected %h", ok ? obs_q[0] : 11'h0, {8'd13, 2'b00, 1'b0});
    end
  endtask

  task automatic test_random();
    int n;
    int k;
    bit acc;
    clear_model();
    n = 0;
    k = 0;
    IN_A = 4'($urandom); IN_B = 4'($urandom_range(0, 15)); IN_FUN = 2'($urandom);
    while (((n < 40) || (obs_q.size() < 40)) && (k < 800)) begin
      OUT_READY = ($urandom_range(0, 3) != 0);
      if (n < 40) IN_VALID = ($urandom_range(0, 2) != 0);
      else        IN_VALID = 1'b0;
      acc = IN_VALID && IN_READY;
      cycle();
      if (acc) begin
        n++;
        IN_A = 4'($urandom); IN_B = 4'($urandom_range(0, 15)); IN_FUN = 2'($urandom);
      end
      k++;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    checks++;
    if ((obs_q.size() != 40) || (exp_q.size() != 40)) begin
      errors++;
      $display("FAIL rand_count: got %0d results for %0d commands expected 40", obs_q.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < 40; i++) begin
      if ((i < obs_q.size()) && (i < exp_q.size())) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_result%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (DIV0_CNT !== div0_cnt_exp()) begin
      errors++;
      $display("FAIL rand_div0_cnt: got %0d expected %0d", DIV0_CNT, div0_cnt_exp());
    end
  endtask

  task automatic test_div0_saturate();
    int k;
    int bad;
    clear_model();
    OUT_READY = 1'b1;
    IN_B = 4'd0; IN_FUN = 2'b11; IN_A = 4'($urandom); IN_VALID = 1'b1;
    k = 0;
    while ((obs_q.size() < 260) && (k < 1500)) begin
      if (exp_q.size() >= 260) IN_VALID = 1'b0;
      cycle();
      k++;
    end
    IN_VALID = 1'b0;
    bad = 0;
    foreach (obs_q[i]) if (obs_q[i] !== {8'hFF, 2'b11, 1'b1}) bad++;
    checks++;
    if ((obs_q.size() != 260) || (bad != 0)) begin
      errors++;
      $display("FAIL sat_results: got %0d results with %0d wrong expected 260 with 0 wrong", obs_q.size(), bad);
    end
    checks++;
    if (DIV0_CNT !== div0_cnt_exp()) begin
      errors++;
      $display("FAIL sat_div0_cnt: got %h expected %h", DIV0_CNT, div0_cnt_exp());
    end
  endtask

  initial begin
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    IN_A = '0;
    IN_B = '0;
    IN_FUN = '0;
    OUT_READY = 1'b0;
    alu_garbage = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_div0();
    test_full();
    test_reset_mid();
    test_random();
    test_div0_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream and downstream wrapper for the registered 4-bit ALU (operands A/B, 2-bit ALU_FUN, 8-bit ALU_OUT, one-cycle latency, no valid or reset). It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU operand inputs, waits out the ALU latency, and captures ALU_OUT into a result register that it presents on a valid/ready output. It also intercepts divide-by-zero so that no X ever leaves the ALU path.

Parameters:
DEPTH, 4, command FIFO entries; power of two, at least 2.
DIV0_VAL, 8'hFF, result substituted for a divide-by-zero command.

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  command valid
IN_READY  output  1  FIFO can accept a command
IN_A  input  4  operand A
IN_B  input  4  operand B
IN_FUN  input  2  op: 00 add, 01 sub, 10 mul, 11 div
ALU_A  output  4  registered operand A to ALU
ALU_B  output  4  registered operand B to ALU
ALU_FUN  output  2  registered function to ALU
ALU_OUT  input  8  ALU result, valid one cycle after operands are applied
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
OUT_RESULT  output  8  captured result
OUT_FUN  output  2  function of the result being presented
OUT_DIV0  output  1  result came from a divide-by-zero command
DIV0_CNT  output  8  saturating count of divide-by-zero commands

Behaviour:
- Reset (asynchronous, while RST_N=0): FIFO empty; pointers and count 0; FSM in IDLE.
- Output values during reset: ALU_A/ALU_B/ALU_FUN=0, OUT_VALID=0, OUT_RESULT=0, OUT_FUN=0, OUT_DIV0=0, DIV0_CNT=0.
- Reset mid-operation drops every buffered and in-flight command. No result is produced for them.
- FIFO handshake: a push happens when IN_VALID && IN_READY. IN_READY = (count != DEPTH), decoded combinationally from count.
- FIFO when full: a push is refused even if a pop happens in the same cycle.
- FIFO simultaneous push and pop when not full: count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- FSM states are IDLE, WAIT and CAPT.
- IDLE -> WAIT when the FIFO is not empty and (!OUT_VALID || OUT_READY). On that edge:
  - pop the FIFO head;
  - load ALU_A, ALU_B and ALU_FUN;
  - latch head FUN and a div0 flag (FUN==11 && B==0) into an internal tag.
- Divide by zero: when the div0 flag is set, ALU_B is driven as 4'd1 instead of 0 so the ALU never divides by zero.
- WAIT -> CAPT unconditionally. The ALU registers its result on this edge.
- CAPT -> IDLE. On that edge:
  - OUT_RESULT <= div0 ? DIV0_VAL : ALU_OUT;
  - OUT_FUN <= tag FUN, OUT_DIV0 <= div0 flag, OUT_VALID <= 1;
  - DIV0_CNT increments if the div0 flag is set, saturating at 8'hFF.
- ALU_OUT is sampled only in CAPT and is ignored in every other state, including the first cycles after reset (the ALU has no reset).
- ALU_A/B/FUN hold their values outside IDLE->WAIT transitions.
- Output handshake: OUT_VALID clears on OUT_VALID && OUT_READY unless CAPT sets it on the same edge.
- The result register cannot be overwritten: an issue requires the slot to be free or freeing, and only CAPT fills it.
- Minimum spacing from issue to result is 2 edges. Peak throughput is 1 result per 3 cycles.
- Arithmetic is passed through unchanged, as 8-bit results from 4-bit operands:
  - sub wraps modulo 256 (2-3 = 8'hFF);
  - mul maximum is 15*15 = 225;
  - div truncates.
- Commands complete in strict FIFO order.

Decomposition:
- Shared package alu_pkg:
  - FUN encodings (FUN_ADD, FUN_SUB, FUN_MUL, FUN_DIV);
  - FSM state encoding (IDLE, WAIT, CAPT);
  - DIV0_VAL default;
  - operand and result width constants (4 and 8).
- One sub-module, alu_cmd_fifo:
  - parameterised DEPTH and width 10 ({FUN,B,A});
  - asynchronous active-low reset;
  - push/pop/full/empty/count interface.
- The FSM, operand registers and result register stay in alu_cmd_sequencer.

Test Plan:
- Reset, then push A=3,B=2,FUN=00 with OUT_READY=1 -> OUT_VALID on the 3rd edge after the push is accepted (push edge, issue edge, wait edge, capture edge), OUT_RESULT=8'h05, OUT_FUN=00, OUT_DIV0=0.
- Push sub 2-3, mul 15*15, div 13/4 back-to-back -> results 8'hFF, 8'hE1, 8'h03 in order with matching OUT_FUN.
- Push div A=9,B=0 -> ALU_B observed as 1 and ALU_FUN as 11 during WAIT; OUT_RESULT=8'hFF, OUT_DIV0=1, DIV0_CNT=1; no X on any output.
- OUT_READY=0, push 6 commands with DEPTH=4:
  - IN_READY drops after 5 accepted (1 issued into the result slot, 4 buffered) and no further issue occurs;
  - release OUT_READY -> all 5 results arrive in order with none lost or duplicated;
  - the pointers wrap.
- FIFO full while the FSM issues, with IN_VALID held -> push is refused that cycle (IN_READY=0) and accepted the next cycle.
- Assert RST_N low during WAIT -> outputs return to reset values immediately (asynchronously); after release, no stale result appears even though ALU_OUT changes; a new command completes normally.
